// File: rtl/csr_countdown_timer.sv
// CSR-programmed countdown timer: TCFG loads/enables, TICLR clears the level TI flag.
// Optional TIMER_DEBUG_FREEZE_EN adds a debug_freeze input that stalls counting in RUN.
module csr_countdown_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcfg_we,
  input  logic [TIMER_W-1:0] tcfg_wdata,
  input  logic               ticlr_we,
  input  logic [31:0]        ticlr_wdata,
`ifdef TIMER_DEBUG_FREEZE_EN
  input  logic               debug_freeze,
`endif
  output logic [TIMER_W-1:0] tcfg_rdata,
  output logic [TIMER_W-1:0] tval_rdata,
  output logic               timer_int,
  output logic               timer_running
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic               ti_q, ti_d;
  logic [0:0]         state_q, state_d;
  logic               freeze;
  logic               counting;
  logic               expire;
  logic               clr_req;
  logic [TIMER_W-1:0] reload_val;
  logic [TIMER_W-1:0] load_val;
  logic               unused_ticlr_bits;

`ifdef TIMER_DEBUG_FREEZE_EN
  assign freeze = debug_freeze;
`else
  assign freeze = 1'b0;
`endif

  assign unused_ticlr_bits = ^ticlr_wdata[31:1];

  assign counting   = (state_q == ST_RUN) && !freeze;
  assign expire     = counting && (tval_q == '0);
  assign clr_req    = ticlr_we && ticlr_wdata[0];
  assign reload_val = {tcfg_q[TIMER_W-1:2], 2'b00};
  assign load_val   = {tcfg_wdata[TIMER_W-1:2], 2'b00};

  always_comb begin
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    ti_d    = ti_q;
    state_d = state_q;

    if (counting) begin
      if (tval_q != '0) begin
        tval_d = tval_q - 1'b1;
      end else if (tcfg_q[1]) begin
        tval_d = reload_val;
      end else begin
        tval_d    = '1;
        state_d   = ST_IDLE;
        tcfg_d[0] = 1'b0;
      end
    end

    // A TCFG write overrides whatever the countdown decided this cycle.
    if (tcfg_we) begin
      tcfg_d = tcfg_wdata;
      if (tcfg_wdata[0]) begin
        tval_d  = load_val;
        state_d = ST_RUN;
      end else begin
        tval_d  = tval_q;
        state_d = ST_IDLE;
      end
    end

    // Set has priority over clear so an expiry is never lost.
    if (clr_req) ti_d = 1'b0;
    if (expire)  ti_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcfg_q  <= '0;
      tval_q  <= '1;
      ti_q    <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      tcfg_q  <= tcfg_d;
      tval_q  <= tval_d;
      ti_q    <= ti_d;
      state_q <= state_d;
    end
  end

  assign tcfg_rdata    = tcfg_q;
  assign tval_rdata    = tval_q;
  assign timer_int     = ti_q;
  assign timer_running = (state_q == ST_RUN);

endmodule

// File: tb/tb_csr_countdown_timer.sv
// Scoreboard bench for csr_countdown_timer: stimulus pushes model predictions, a monitor pops and compares.
module tb_csr_countdown_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tcfg_we = 1'b0;
  logic [31:0] tcfg_wdata = '0;
  logic        ticlr_we = 1'b0;
  logic [31:0] ticlr_wdata = '0;
  logic [31:0] tcfg_rdata;
  logic [31:0] tval_rdata;
  logic        timer_int;
  logic        timer_running;

  csr_countdown_timer #(.TIMER_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .tcfg_we      (tcfg_we),
    .tcfg_wdata   (tcfg_wdata),
    .ticlr_we     (ticlr_we),
    .ticlr_wdata  (ticlr_wdata),
    .tcfg_rdata   (tcfg_rdata),
    .tval_rdata   (tval_rdata),
    .timer_int    (timer_int),
    .timer_running(timer_running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tval;
    logic [31:0] tcfg;
    logic        ti;
    logic        run;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a load at edge L with InitVal I gives period P=4I+1.
  // k edges after the load, tval = 4I - (k mod P); expiry happens whenever k>0 and k mod P == 0.
  int          m_e, m_load, m_i;
  bit          m_active, m_per, m_ti;
  logic [31:0] m_tcfg, m_held;

  function automatic logic [31:0] tval_at(input int k);
    int p;
    p = 4 * m_i + 1;
    if (m_per) return 32'(4 * m_i - (k % p));
    return 32'(4 * m_i - k);
  endfunction

  task automatic model_reset();
    m_e = 0; m_load = 0; m_i = 0;
    m_active = 0; m_per = 0; m_ti = 0;
    m_tcfg = '0; m_held = 32'hFFFF_FFFF;
  endtask

  task automatic model_edge(input bit we, input logic [31:0] wd, input bit cwe, input logic [31:0] cwd);
    int k, p;
    bit expire;
    logic [31:0] cur;
    exp_t e;
    m_e++;
    k = m_e - m_load;
    p = 4 * m_i + 1;
    cur = m_active ? tval_at(k - 1) : m_held;
    expire = m_active && (m_per ? (k > 0 && (k % p) == 0) : (k == p));
    if (we) begin
      m_tcfg = wd;
      if (wd[0]) begin
        m_active = 1; m_load = m_e; m_per = wd[1]; m_i = int'(wd[31:2]);
      end else begin
        m_active = 0; m_held = cur;
      end
    end else if (expire && !m_per) begin
      m_active = 0; m_held = 32'hFFFF_FFFF; m_tcfg[0] = 1'b0;
    end
    if (cwe && cwd[0]) m_ti = 0;
    if (expire) m_ti = 1;
    e.tval = m_active ? tval_at(m_e - m_load) : m_held;
    e.tcfg = m_tcfg;
    e.ti   = m_ti;
    e.run  = m_active;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit we, input logic [31:0] wd, input bit cwe, input logic [31:0] cwd);
    @(negedge clk);
    reset       = 1'b0;
    tcfg_we     = we;
    tcfg_wdata  = wd;
    ticlr_we    = cwe;
    ticlr_wdata = cwd;
    model_edge(we, wd, cwe, cwd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0);
  endtask

  // Monitor: outputs are registered, so there is one prediction per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("tval", tval_rdata, e.tval);
        chk("tcfg", tcfg_rdata, e.tcfg);
        chk("timer_int", {31'b0, timer_int}, {31'b0, e.ti});
        chk("timer_running", {31'b0, timer_running}, {31'b0, e.run});
      end
    end
  end

  initial begin
    bit          we, cwe;
    logic [31:0] wd, cwd;
    int          wait_cycles;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tval", tval_rdata, 32'hFFFF_FFFF);
    chk("rst_tcfg", tcfg_rdata, 32'h0);
    chk("rst_ti", {31'b0, timer_int}, 32'h0);
    chk("rst_run", {31'b0, timer_running}, 32'h0);

    // One-shot, InitVal=4.
    step(1, 32'h11, 0, '0);
    idle(20);

    // Periodic InitVal=2: clear on the expiry edge, then on a quiet edge.
    step(1, 32'h0B, 0, '0);
    idle(8);
    step(0, '0, 1, 32'h1);
    step(0, '0, 1, 32'h1);
    idle(7);
    step(0, '0, 1, 32'hFFFF_FFFE);
    idle(4);
    step(0, '0, 1, 32'h1);

    // Reprogram mid-count at tval=5, then halt.
    step(1, 32'h11, 0, '0);
    idle(11);
    step(1, 32'h21, 0, '0);
    idle(6);
    step(1, 32'h0, 1, 32'h1);
    idle(5);

    // Asynchronous reset between edges while running.
    step(1, 32'h11, 0, '0);
    idle(5);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_tval", tval_rdata, 32'hFFFF_FFFF);
    chk("arst_tcfg", tcfg_rdata, 32'h0);
    chk("arst_ti", {31'b0, timer_int}, 32'h0);
    chk("arst_run", {31'b0, timer_running}, 32'h0);
    model_reset();
    idle(4);

    // InitVal=0, periodic: TI reasserted every edge despite TICLR.
    step(1, 32'h03, 0, '0);
    for (int i = 0; i < 6; i++) step(0, '0, 1, 32'h1);
    step(1, 32'h0, 1, 32'h1);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      we  = ($urandom_range(0, 15) == 0);
      wd  = (32'($urandom_range(0, 5)) << 2) | (32'($urandom_range(0, 1)) << 1)
          | 32'($urandom_range(0, 3) != 0);
      cwe = ($urandom_range(0, 3) == 0);
      cwd = $urandom;
      step(we, wd, cwe, cwd);
    end
    idle(2);

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d predictions left, required 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_countdown_timer.md
Name: csr_countdown_timer

Overview:
- Programmable countdown timer: the interrupt-generating counterpart to the free-running stable counter.
- Software programs it through CSR writes: TCFG for config, TICLR for interrupt clear.
- Counts down each clock and raises a level timer interrupt (TI) on expiry; optionally reloads for periodic operation.
- Sits beside the CSR file; timer_int feeds the interrupt-pending logic (ESTAT.IS[11]); tcfg_rdata and tval_rdata feed the CSR read mux.

Parameters:
- TIMER_W, 32, counter width; TCFG.InitVal occupies bits [TIMER_W-1:2]. Legal range 8..32.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- tcfg_we  input  1  single-cycle write strobe for TCFG
- tcfg_wdata  input  TIMER_W  TCFG write data: [0] En, [1] Periodic, [W-1:2] InitVal
- ticlr_we  input  1  single-cycle write strobe for TICLR
- ticlr_wdata  input  32  TICLR write data; bit [0] CLR, other bits ignored
- tcfg_rdata  output  TIMER_W  current TCFG register
- tval_rdata  output  TIMER_W  current countdown value
- timer_int  output  1  TI flag, level, stays high until cleared
- timer_running  output  1  high while in state RUN

Behaviour:
- Reset, asynchronous, effective immediately: tcfg=0, tval=all-ones, TI=0, state=IDLE. timer_int=0, timer_running=0.
- States:
  - IDLE: not counting; tval holds its value.
  - RUN: decrementing.
- TCFG write (tcfg_we=1) at edge N:
  - tcfg <= tcfg_wdata.
  - If wdata[0]=1: tval <= {wdata[W-1:2], 2'b00}; state <= RUN; visible at N+1; first decrement at edge N+1.
  - If wdata[0]=0: state <= IDLE; tval unchanged.
- RUN, no TCFG write:
  - tval != 0: tval <= tval - 1.
  - tval == 0: expiry. TI <= 1.
    - Periodic=1: tval <= {InitVal, 2'b00}, remain RUN.
    - Periodic=0: tval <= all-ones, state <= IDLE, tcfg.En <= 0.
- Expiry timing: a period is InitVal*4 + 1 cycles from the load to the TI rise. Periodic repeats at the same interval.
- InitVal=0 with En=1: tval=0 at N+1; TI rises at N+2.
  - Periodic: TI is re-asserted every cycle.
  - Non-periodic: single shot.
- TICLR: ticlr_we=1 with ticlr_wdata[0]=1 clears TI next edge; wdata[0]=0 has no effect. TICLR reads as 0 and is not stored here.
- Simultaneous events, same edge:
  - Expiry and TI clear: set wins, TI stays 1, so no event is lost.
  - TCFG write and expiry: the TCFG write defines tval, tcfg and state; TI is still set by the expiry.
  - TCFG write and TICLR: both are applied independently.
- Width rule: all arithmetic is modulo 2^TIMER_W; wrap is possible only via the explicit all-ones load.
- tval_rdata, tcfg_rdata and timer_int are direct register outputs; no combinational path from inputs.
- Reset asserted mid-count forces the reset values immediately; counting resumes only after a new TCFG write with En=1.

Optional Feature:
- Macro TIMER_DEBUG_FREEZE_EN.
- Defined:
  - Adds input port debug_freeze (1 bit), placed after ticlr_wdata.
  - While debug_freeze=1 in RUN: tval holds and expiry is suppressed.
  - TCFG and TICLR writes still take effect.
  - Counting resumes on the first cycle debug_freeze=0.
- Not defined: no such port; the timer always counts in RUN.

Test Plan:
- One-shot: reset, write TCFG=0x0000_0011 (InitVal=4, En=1, Periodic=0) -> tval=16 next cycle; TI rises 17 cycles after the write edge; then tval=0xFFFF_FFFF, tcfg=0x0000_0010, timer_running=0.
- Periodic: TCFG=0x0000_000B (InitVal=2, En, Periodic) -> TI rises at 9 cycles. Clear it with TICLR=1, then TI re-rises 9 cycles after the previous rise; tval reloads to 8 each time.
- Clear race: in periodic mode, assert TICLR CLR on the exact expiry cycle -> TI remains 1. TICLR on a non-expiry cycle -> TI=0 next cycle.
- Reprogram mid-count: at tval=5, write TCFG=0x0000_0021 -> tval=32 next cycle with no TI. Write TCFG=0x0000_0000 -> timer halts and tval holds.
- Async reset: assert reset between clock edges while in RUN -> all outputs reach reset values before the next edge. Deassert -> remains IDLE, tval=0xFFFF_FFFF.
- InitVal=0 edge case: TCFG=0x0000_0003 -> TI high from 2 cycles after the write and held; TICLR each cycle cannot drop it.
